// File: rtl/paddle_pkg.sv
// paddle_pkg: shared phase encoding, floating-pot value and counter width for the pot sampler
package paddle_pkg;
  typedef enum logic {PH_DISCHARGE = 1'b0, PH_CHARGE = 1'b1} phase_t;
  localparam logic [7:0] POT_FLOAT = 8'hFF;
  localparam int CNT_W = 10;
endpackage

// File: rtl/paddle_pot_sampler_if.sv
// paddle_pot_sampler_if: paddle inputs and pot register outputs of the sampler
interface paddle_pot_sampler_if;
  logic [1:0][7:0] pd_in;
  logic [1:0] pd_valid;
  logic [7:0] pot_x;
  logic [7:0] pot_y;
  logic [1:0] pot_line;
  logic sample_strobe;
  logic phase;
  modport master(output pd_in, pd_valid, input pot_x, pot_y, pot_line, sample_strobe, phase);
  modport slave(input pd_in, pd_valid, output pot_x, pot_y, pot_line, sample_strobe, phase);
endinterface

// File: rtl/pot_channel.sv
// pot_channel: one pot axis -- target latch, threshold capture and rounded two-sample average
module pot_channel
  import paddle_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             charge,
  input  logic             latch,
  input  logic             done,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       pd,
  input  logic             valid,
  output logic [7:0]       pot,
  output logic             line
);
  logic [7:0] target, cap, cap_n, hist, avg;
  logic valid_l, fired, hit, fire;
  // the capture taken on the final charge tick must reach the average in the same clk
  always_comb begin
    hit = ~|cnt[CNT_W-1:8] && (cnt[7:0] >= target);
    fire = ce && charge && !fired && hit;
    cap_n = fire ? cnt[7:0] : cap;
    avg = 8'(({1'b0, hist} + {1'b0, cap_n} + 9'd1) >> 1);
    line = charge && (fired || hit);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      target <= POT_FLOAT;
      cap <= POT_FLOAT;
      hist <= POT_FLOAT;
      pot <= POT_FLOAT;
      valid_l <= 1'b0;
      fired <= 1'b0;
    end else begin
      if (latch) begin
        target <= valid ? pd : POT_FLOAT;
        valid_l <= valid;
        cap <= POT_FLOAT;
        fired <= 1'b0;
      end
      if (fire) begin
        cap <= cnt[7:0];
        fired <= 1'b1;
      end
      if (done) begin
        pot <= valid_l ? avg : POT_FLOAT;
        hist <= valid_l ? cap_n : POT_FLOAT;
      end
    end
endmodule

// File: rtl/paddle_pot_sampler.sv
// paddle_pot_sampler: discharge/charge pot emulation with shared phase counter and two pot channels
module paddle_pot_sampler
  import paddle_pkg::*;
#(
  parameter int DISCH_TICKS  = 256,
  parameter int CHARGE_TICKS = 256
) (
  input logic clk,
  input logic reset,
  input logic ce,
  paddle_pot_sampler_if.slave bus
);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DISCH_TICKS - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CHARGE_TICKS - 1);
  phase_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic latch, done, charge;
  logic [1:0][7:0] pot;
  logic [1:0] line;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= PH_DISCHARGE;
      cnt <= '0;
      bus.sample_strobe <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.sample_strobe <= done;
    end
  always_comb begin
    latch = ce && state == PH_DISCHARGE && cnt == D_LAST;
    done = ce && state == PH_CHARGE && cnt == C_LAST;
    state_n = latch ? PH_CHARGE : done ? PH_DISCHARGE : state;
    cnt_n = (latch || done) ? '0 : ce ? cnt + CNT_W'(1) : cnt;
  end
  always_comb begin
    charge = state == PH_CHARGE;
    bus.phase = charge;
    bus.pot_x = pot[0];
    bus.pot_y = pot[1];
    bus.pot_line = line;
  end
  for (genvar i = 0; i < 2; i++) begin : g_ch
    pot_channel u_ch (
      .clk(clk),
      .reset(reset),
      .ce(ce),
      .charge(charge),
      .latch(latch),
      .done(done),
      .cnt(cnt),
      .pd(bus.pd_in[i]),
      .valid(bus.pd_valid[i]),
      .pot(pot[i]),
      .line(line[i])
    );
  end
endmodule

// File: doc/paddle_pot_sampler.md
PADDLE_POT_SAMPLER -- requirements
Module: paddle_pot_sampler

Interface
REQ-001 Parameter DISCH_TICKS, default 256: length of the discharge phase in ce ticks (range 2..1024).
REQ-002 Parameter CHARGE_TICKS, default 256: length of the charge phase in ce ticks; it SHALL be at least 256.
REQ-003 Ports SHALL be: clk  in  1  system clock; the single clock of the block.
REQ-004 reset  in  1  reset; asynchronous and active-high.
REQ-005 ce  in  1  CPU-rate clock enable (phi2); all timing advances only on clk edges where ce=1.
REQ-006 pd_in  in  [1:0][7:0]  paddle values from the paddle chooser (pd_out slice for this port); index 0=POTX, 1=POTY.
REQ-007 pd_valid  in  [1:0]  per-axis paddle assigned/present flag.
REQ-008 pot_x, pot_y  out  8 each  filtered pot register values presented to the VIC register file.
REQ-009 pot_line  out  [1:0]  emulated comparator level per axis (1 = capacitor above threshold).
REQ-010 sample_strobe  out  1  one-clk pulse when pot_x/pot_y update.
REQ-011 phase  out  1  0=DISCHARGE, 1=CHARGE; provided for debug and for the register read mux.

Function
REQ-012 The FSM SHALL have exactly two states, DISCHARGE and CHARGE, plus one tick counter of 10 bits.
REQ-013 DISCHARGE: the counter increments each ce; after DISCH_TICKS ticks, go to CHARGE with counter=0; pot_line=2'b00 throughout.
REQ-014 On the DISCHARGE->CHARGE transition each axis SHALL latch its target: pd_in[i] if pd_valid[i], else 8'hFF; pd_in changes during CHARGE SHALL be ignored.
REQ-015 CHARGE: the counter increments each ce; axis i fires on the first ce tick where counter[7:0] >= target[i] and counter < 256. It then captures counter[7:0] and sets pot_line[i]=1 until the phase ends.
REQ-016 Target 0 SHALL fire on the first CHARGE tick (capture 0); target 255 SHALL fire at count 255.
REQ-017 An axis that has not fired by count 255 SHALL capture 8'hFF.
REQ-018 After CHARGE_TICKS ticks, go to DISCHARGE with counter=0. In the same clk, update pot_x/pot_y and pulse sample_strobe for exactly one clk, regardless of ce on the following clk.
REQ-019 Update rule per axis when valid: out = (hist + capture + 1) >> 1 using a 9-bit sum, then hist <= capture.
REQ-020 Update rule when the latched target came from pd_valid=0: out = 8'hFF and hist = 8'hFF, with no averaging.
REQ-021 ce=0 SHALL freeze the state, counter, captures and pot_line; sample_strobe SHALL still self-clear after one clk.
REQ-022 Throughput: one sample per DISCH_TICKS+CHARGE_TICKS ce ticks (512 at defaults). Latency from latch to output is CHARGE_TICKS ce ticks.

Reset
REQ-023 Reset asserted SHALL immediately force: state=DISCHARGE, counter=0, pot_x=pot_y=8'hFF, hist=8'hFF, targets=8'hFF, pot_line=0, sample_strobe=0, phase=0.
REQ-024 Reset mid-CHARGE SHALL discard in-progress captures. After release, the first sample_strobe SHALL occur DISCH_TICKS+CHARGE_TICKS ce ticks later.

Structure
REQ-025 Package paddle_pkg SHALL hold the phase enum (PH_DISCHARGE, PH_CHARGE), the POT_FLOAT=8'hFF constant, and the counter width.
REQ-026 Sub-module pot_channel SHALL hold the per-axis target latch, the fire/capture logic, hist, and the average. It SHALL be instantiated twice, with the FSM and counter shared in paddle_pot_sampler.

Verification
REQ-027 Reset release, pd_valid=2'b00, ce every clk -> first sample_strobe at tick 512; pot_x=pot_y=8'hFF; pot_line stays 0 during DISCHARGE and goes 1 at count 255.
REQ-028 pd_valid=2'b11, pd_in={8'h40, 8'h00} held -> pot_line[0] rises on CHARGE tick 0 and pot_line[1] at tick 64. After two samples pot_x=8'h00 and pot_y=8'h40; after the first sample pot_y=8'h A0 ((FF+40+1)>>1).
REQ-029 pd_in[0] changes 8'h10->8'hF0 at CHARGE tick 5 -> that sample captures 8'h10; the next sample captures 8'hF0, and the output is the rounded average 8'h80.
REQ-030 ce asserted 1 clk in 4 -> identical pot values, with the strobe interval exactly 4x in clks; strobe width remains 1 clk.
REQ-031 Reset asserted at CHARGE tick 100 with pd_in=8'h20 -> outputs go to 8'hFF asynchronously, no strobe occurs, and the first post-reset strobe is at ce tick 512.
REQ-032 pd_valid[1] drops between samples with pot_y=8'h40 -> the next update gives pot_y=8'hFF with no averaging.
